// File: rtl/tahmin_kontrol.sv
// tahmin_kontrol: round controller feeding step counts and a guess into tahmin, scoring each round.
// Optional guess-window timeout is built only when TAHMIN_ZAMAN_ASIMI_EN is defined.
module tahmin_kontrol #(
  parameter int ZAMAN_ASIMI = 1000,
  parameter int SAYAC_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               basla,
  input  logic               sag_btn,
  input  logic               asagi_btn,
  input  logic               onayla,
  input  logic [3:0]         sayi_giris,
  input  logic               tahmin_dogru,
  output logic [1:0]         sag_adim,
  output logic [1:0]         asagi_adim,
  output logic [3:0]         sayi,
  output logic [2:0]         durum,
  output logic               sonuc_dogru,
  output logic               sonuc_gecerli,
  output logic               hata,
  output logic               zaman_asimi,
  output logic [SAYAC_W-1:0] dogru_sayac,
  output logic [SAYAC_W-1:0] yanlis_sayac
);

  // state  | meaning
  // BOSTA  | idle, steps and guess held at 0
  // ADIM   | collecting right/down step presses
  // TAHMIN | waiting for a confirmed guess in 1..9
  // KARAR  | one cycle: score the settled tahmin_dogru
  // SONUC  | holding the round result until restart
  localparam logic [2:0] BOSTA  = 3'd0;
  localparam logic [2:0] ADIM   = 3'd1;
  localparam logic [2:0] TAHMIN = 3'd2;
  localparam logic [2:0] KARAR  = 3'd3;
  localparam logic [2:0] SONUC  = 3'd4;

  localparam logic [SAYAC_W-1:0] SAYAC_MAX = '1;

  logic basla_q, sag_q, asagi_q, onayla_q;
  logic basla_ev, sag_ev, asagi_ev, onayla_ev;
  logic onay_gecerli;
  logic sure_doldu;

  assign basla_ev     = basla & ~basla_q;
  assign sag_ev       = sag_btn & ~sag_q;
  assign asagi_ev     = asagi_btn & ~asagi_q;
  assign onayla_ev    = onayla & ~onayla_q;
  assign onay_gecerli = onayla_ev && (sayi_giris != 4'd0) && (sayi_giris <= 4'd9);

`ifdef TAHMIN_ZAMAN_ASIMI_EN
  localparam int PENCERE_W = (ZAMAN_ASIMI > 2) ? $clog2(ZAMAN_ASIMI) : 1;

  logic [PENCERE_W-1:0] pencere;

  assign sure_doldu = (pencere == PENCERE_W'(ZAMAN_ASIMI - 1));

  // Held at zero outside TAHMIN, so every entry starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst || durum != TAHMIN)
      pencere <= '0;
    else if (!sure_doldu)
      pencere <= pencere + 1'b1;
  end
`else
  assign sure_doldu = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      basla_q       <= 1'b0;
      sag_q         <= 1'b0;
      asagi_q       <= 1'b0;
      onayla_q      <= 1'b0;
      durum         <= BOSTA;
      sag_adim      <= 2'd0;
      asagi_adim    <= 2'd0;
      sayi          <= 4'd0;
      sonuc_dogru   <= 1'b0;
      sonuc_gecerli <= 1'b0;
      hata          <= 1'b0;
      zaman_asimi   <= 1'b0;
      dogru_sayac   <= '0;
      yanlis_sayac  <= '0;
    end else begin
      basla_q       <= basla;
      sag_q         <= sag_btn;
      asagi_q       <= asagi_btn;
      onayla_q      <= onayla;
      sonuc_gecerli <= 1'b0;
      hata          <= 1'b0;
      case (durum)
        BOSTA: begin
          sag_adim   <= 2'd0;
          asagi_adim <= 2'd0;
          sayi       <= 4'd0;
          if (basla_ev) durum <= ADIM;
        end
        ADIM: begin
          if (basla_ev) begin
            sag_adim   <= 2'd0;
            asagi_adim <= 2'd0;
          end else if (onayla_ev) begin
            durum <= TAHMIN;
          end else begin
            if (sag_ev && sag_adim != 2'd3)     sag_adim   <= sag_adim + 2'd1;
            if (asagi_ev && asagi_adim != 2'd3) asagi_adim <= asagi_adim + 2'd1;
          end
        end
        TAHMIN: begin
          if (basla_ev) begin
            sag_adim   <= 2'd0;
            asagi_adim <= 2'd0;
            sayi       <= 4'd0;
            durum      <= ADIM;
          end else if (onay_gecerli) begin
            sayi  <= sayi_giris;
            durum <= KARAR;
          end else begin
            if (onayla_ev) hata <= 1'b1;
            // Expired window scores as a wrong round without passing through KARAR.
            if (sure_doldu) begin
              if (yanlis_sayac != SAYAC_MAX) yanlis_sayac <= yanlis_sayac + 1'b1;
              sonuc_dogru   <= 1'b0;
              zaman_asimi   <= 1'b1;
              sonuc_gecerli <= 1'b1;
              durum         <= SONUC;
            end
          end
        end
        KARAR: begin
          sonuc_dogru <= tahmin_dogru;
          if (tahmin_dogru) begin
            if (dogru_sayac != SAYAC_MAX) dogru_sayac <= dogru_sayac + 1'b1;
          end else begin
            if (yanlis_sayac != SAYAC_MAX) yanlis_sayac <= yanlis_sayac + 1'b1;
          end
          zaman_asimi   <= 1'b0;
          sonuc_gecerli <= 1'b1;
          durum         <= SONUC;
        end
        SONUC: begin
          if (basla_ev) begin
            sag_adim   <= 2'd0;
            asagi_adim <= 2'd0;
            sayi       <= 4'd0;
            durum      <= ADIM;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: doc/tahmin_kontrol.md
# tahmin_kontrol

Sequential round controller sitting directly upstream of the combinational `tahmin` keypad-guess block. It turns raw push-button levels into right/down step counts and a registered guess number, and drives those into `tahmin`. It samples `tahmin_dogru` back, scores each round and reports round status to the board I/O.

## Interface
Parameters:
- `ZAMAN_ASIMI`, default 1000: guess-window length in clock cycles. Only used with `TAHMIN_ZAMAN_ASIMI_EN`; legal range ≥ 2.
- `SAYAC_W`, default 8: width of the score counters.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `basla` in 1: start/restart button, level.
- `sag_btn` in 1: right-step button, level.
- `asagi_btn` in 1: down-step button, level.
- `onayla` in 1: confirm button, level.
- `sayi_giris` in 4: switch value for the guess.
- `tahmin_dogru` in 1: result fed back from `tahmin`.
- `sag_adim` out 2: registered, to `tahmin`.
- `asagi_adim` out 2: registered, to `tahmin`.
- `sayi` out 4: registered guess, to `tahmin`.
- `durum` out 3: current FSM state encoding.
- `sonuc_dogru` out 1: result of the last round.
- `sonuc_gecerli` out 1: one-cycle pulse when a round is scored.
- `hata` out 1: one-cycle pulse when an invalid guess is rejected.
- `zaman_asimi` out 1: set if the last round timed out.
- `dogru_sayac` out SAYAC_W: count of correct rounds.
- `yanlis_sayac` out SAYAC_W: count of wrong rounds.

## Operation
Edge detection:
- Each button has one history register, reset to 0.
- Event = button high at the current edge and low at the previous edge.
- A held button produces exactly one event.

States (`durum` encoding):

- **BOSTA = 0**
  - Step registers and `sayi` are held at 0.
  - `basla` event → ADIM.

- **ADIM = 1**
  - Event priority, per cycle: `basla` > `onayla` > step buttons.
  - `basla` event: clear both step registers, stay in ADIM.
  - `onayla` event → TAHMIN. Any step events in the same cycle are ignored.
  - Otherwise, each `sag_btn` event increments `sag_adim` and each `asagi_btn` event increments `asagi_adim`. Both saturate at 3. Simultaneous right and down events both apply.

- **TAHMIN = 2**
  - Step buttons are ignored.
  - `onayla` event with `sayi_giris` in 1..9: latch it into `sayi`, go to KARAR.
  - `onayla` event with `sayi_giris` = 0 or ≥ 10: pulse `hata`, stay in TAHMIN, leave `sayi` unchanged.
  - `basla` event: return to ADIM with steps and `sayi` cleared. The round is not scored.

- **KARAR = 3** (one cycle)
  - Sample `tahmin_dogru` into `sonuc_dogru`.
  - Increment `dogru_sayac` or `yanlis_sayac` accordingly. Both counters saturate at all-ones.
  - Clear `zaman_asimi`, pulse `sonuc_gecerli`, go to SONUC.

- **SONUC = 4**
  - Hold all outputs.
  - `basla` event: clear steps and `sayi`, go to ADIM.

Encodings 5–7 are unreachable. If entered, go to BOSTA on the next edge.

Score counters and `sonuc_dogru` are cleared only by `rst`.

## Timing
Reset values:
- All outputs are 0.
- `durum` = BOSTA.
- Edge-history registers are 0, so a button already held high during reset produces an event on the first cycle after reset.

Latencies:
- An event sampled at edge N updates the step registers, `sayi` and `durum` at edge N.
- They are visible to `tahmin` during cycle N..N+1.
- A valid `onayla` event at edge N (in TAHMIN):
  - `durum` = KARAR after edge N.
  - `tahmin` output settles combinationally during that cycle.
  - At edge N+1: counters update, `sonuc_dogru` is set, `sonuc_gecerli` = 1 for exactly one cycle, `durum` = SONUC.

Pulses:
- `hata` and `sonuc_gecerli` are registered and last one cycle.

Reset mid-operation:
- `rst` at any edge overrides every event in that cycle.
- All state returns to reset values, including the score counters.

## Configuration
Macro: `TAHMIN_ZAMAN_ASIMI_EN`.

Defined:
- A cycle counter clears on entry to TAHMIN and increments every cycle spent there.
- When it reaches `ZAMAN_ASIMI`-1 with no valid `onayla` event, the round scores as wrong:
  - `yanlis_sayac` +1
  - `sonuc_dogru` = 0
  - `zaman_asimi` = 1
  - `sonuc_gecerli` pulses
  - go to SONUC, skipping KARAR.
- A valid `onayla` event in the same cycle as expiry wins.

Not defined:
- No counter is built.
- TAHMIN waits indefinitely.
- `zaman_asimi` is tied to 0.

## Test plan
- **Correct guess:** reset, `basla`, right ×2, down ×1, `onayla`, `sayi_giris`=6, `onayla` → KARAR, then `sonuc_dogru`=1, `dogru_sayac`=1, `sonuc_gecerli` pulse 1 cycle.
- **Saturation:** right ×5, down ×4 → `sag_adim`=3, `asagi_adim`=3. Then guess 8 → `yanlis_sayac`=1 (`tahmin` yields 9).
- **Held button:** `sag_btn` held for 20 cycles → `sag_adim`=1. Simultaneous `sag_btn`/`asagi_btn` events → both = 1. `onayla` together with `sag_btn` in ADIM → TAHMIN, `sag_adim` unchanged.
- **Invalid entry:** in TAHMIN, `sayi_giris`=0 then 10 with `onayla` → two `hata` pulses, stays TAHMIN, `sayi`=0. Then 1 → KARAR.
- **Timeout** (macro on, `ZAMAN_ASIMI`=8): no confirm → `zaman_asimi`=1, `yanlis_sayac`+1, SONUC after 8 cycles in TAHMIN. Confirm in the expiry cycle → scored normally.
- **Reset mid-round:** `rst` in TAHMIN with `dogru_sayac`=3 → all outputs 0, `durum`=BOSTA next cycle.
